imem_program_loader: RTL and testbench
======================================

# imem_program_loader

- Sequential instruction encoder and loader: the write-side counterpart of the pipeline's instruction decoder.
- Accepts symbolic instruction commands over a valid/ready stream and packs them into 32-bit MIPS words (add, sub, ori, lw, sw, beq, jal, nop) using the same opcode/funct encodings the decoder consumes (`OP_*`, `FN_*` in declarations.v).
- Writes the words sequentially into instruction memory and holds the CPU pipeline stalled until a complete program has been loaded.

## Interface
- AW, 10, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after each start

Clock and reset:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset, synchronous, active-low

Control and command stream:
- start  in  1  begin a new load; honoured only in IDLE or ERR
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader can accept a command
- cmd_kind  in  3  0 add, 1 sub, 2 ori, 3 lw, 4 sw, 5 beq, 6 jal, 7 nop
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields
- cmd_imm  in  16  immediate for ori/lw/sw/beq
- cmd_target  in  26  jal target field
- cmd_last  in  1  marks the final command of the program

Memory and status:
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  AW  word address
- imem_wdata  out  32  encoded instruction
- cpu_hold  out  1  stall PC and IF/ID while high
- done  out  1  one-cycle pulse when a load completes
- err_ovf  out  1  sticky overflow flag
- count  out  AW+1  number of words written in the current load

## Operation
- States: IDLE, LOAD, DRAIN, DONE, ERR.
- Encoding, with fields in MIPS order op|rs|rt|rd|shamt|funct or op|rs|rt|imm:
  - add = {000000, rs, rt, rd, 00000, 100000}
  - sub = the same with funct 100010
  - ori = {001101, rs, rt, imm}
  - lw = {100011, rs, rt, imm}
  - sw = {101011, rs, rt, imm}
  - beq = {000100, rs, rt, imm}
  - jal = {000011, target}
  - nop = 32'h0
  - Fields not used by a kind are ignored.
- Transitions:
  - IDLE --start--> LOAD: write pointer = BASE_ADDR, count = 0, err_ovf cleared.
  - In LOAD, cmd_ready = 1. A handshake (cmd_valid & cmd_ready) registers the encoded word and current pointer, then increments pointer and count.
  - Handshake with cmd_last -> DRAIN.
  - Handshake at pointer = 2^AW−1 without cmd_last -> ERR.
  - DRAIN -> DONE (unconditional). DONE -> IDLE (unconditional); sets the internal `loaded` flag.
  - ERR: err_ovf = 1 and cmd_ready = 0. Leaves only on start, which goes to LOAD.
  - start is ignored in LOAD, DRAIN and DONE.
- Handshake at pointer = 2^AW−1 with cmd_last: normal completion; the pointer wraps to 0 but is unused.
- cpu_hold = 0 only in IDLE with loaded = 1; otherwise 1. A new start clears loaded.
- cmd_ready = 1 only in LOAD. It does not depend on cmd_valid (no combinational path from valid to ready).

## Timing
- Reset (rst_n low at an edge):
  - Outputs go to: state IDLE, loaded 0, cmd_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, done 0, err_ovf 0, count 0.
  - Reset mid-load abandons the load; the memory contents are whatever was already written, and cpu_hold stays 1.
- Write latency: a handshake at edge N produces imem_we = 1 with the registered addr/wdata during cycle N+1 (1 cycle). imem_we is high for exactly one cycle per accepted command.
- Back-to-back handshakes produce back-to-back writes at consecutive addresses, sustaining 1 word/cycle.
- Last word: its handshake moves the FSM to DRAIN, and its write occurs during the DRAIN cycle. done is high during the DONE cycle; cpu_hold falls the cycle after DONE, when the FSM is in IDLE.
- count updates at the handshake edge. It is final and stable from DRAIN onwards until the next start.
- start together with cmd_valid in IDLE: only start acts; cmd_ready is 0 that cycle.

## Test plan
- start, then add rs=1 rt=2 rd=3 with cmd_last -> one write, addr 0, wdata 0x00221820; done one cycle later; count = 1; cpu_hold falls the cycle after done.
- Back-to-back stream ori rs=0 rt=5 imm=0x00FF; lw rs=1 rt=4 imm=8; sw rs=1 rt=4 imm=4; jal target=0x10 (last) -> writes 0x340500FF, 0x8C240008, 0xAC240004, 0x0C000010 at addrs 0..3 on consecutive cycles; count = 4.
- cmd_valid toggled randomly during LOAD -> writes occur only after handshakes, addresses contiguous, no gaps or duplicates.
- AW=2, five commands with no cmd_last -> four writes at 0..3, then ERR: err_ovf = 1, cmd_ready = 0, cpu_hold = 1, fifth command never accepted. A subsequent start clears err_ovf and restarts at address 0.
- rst_n low for one cycle after two accepted commands -> all outputs at reset values, cpu_hold = 1, the next start reloads from address 0.
- start pulsed during LOAD and DONE -> ignored; pointer and count undisturbed.

Source files
------------

// File: rtl/imem_program_loader_if.sv
// Command stream plus instruction-memory write bus for the program loader.
// The master side issues commands and consumes memory writes; the slave side
// is the loader itself.
interface imem_program_loader_if #(
  parameter int AW = 10
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_kind;
  logic [4:0]    cmd_rs;
  logic [4:0]    cmd_rt;
  logic [4:0]    cmd_rd;
  logic [15:0]   cmd_imm;
  logic [25:0]   cmd_target;
  logic          cmd_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, cmd_last,
    input  cmd_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, cmd_last,
    output cmd_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_program_loader.sv
// imem_program_loader: packs symbolic commands into MIPS instruction words,
// writes them sequentially into instruction memory and holds the CPU stalled
// until a complete program has been loaded.
module imem_program_loader #(
  parameter int          AW        = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  imem_program_loader_if.slave bus,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err_ovf,
  output logic [AW:0]          count
);
  // Opcode / funct values shared with the pipeline decoder.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  localparam logic [2:0] K_ADD = 3'd0;
  localparam logic [2:0] K_SUB = 3'd1;
  localparam logic [2:0] K_ORI = 3'd2;
  localparam logic [2:0] K_LW  = 3'd3;
  localparam logic [2:0] K_SW  = 3'd4;
  localparam logic [2:0] K_BEQ = 3'd5;
  localparam logic [2:0] K_JAL = 3'd6;

  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERR} state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } cmd_t;

  state_t        state, state_n;
  cmd_t          cmd;
  logic          rdy, hs, at_top, load_go;
  logic [AW-1:0] ptr;
  logic [AW:0]   count_q;
  logic          we_q, ovf_q, loaded;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  // Field selection per kind; unused fields of a kind are simply dropped.
  function automatic logic [31:0] encode(input cmd_t c);
    case (c.kind)
      K_ADD:   return {OP_RTYPE, c.rs, c.rt, c.rd, 5'd0, FN_ADD};
      K_SUB:   return {OP_RTYPE, c.rs, c.rt, c.rd, 5'd0, FN_SUB};
      K_ORI:   return {OP_ORI, c.rs, c.rt, c.imm};
      K_LW:    return {OP_LW,  c.rs, c.rt, c.imm};
      K_SW:    return {OP_SW,  c.rs, c.rt, c.imm};
      K_BEQ:   return {OP_BEQ, c.rs, c.rt, c.imm};
      K_JAL:   return {OP_JAL, c.target};
      default: return 32'h0000_0000;  // nop
    endcase
  endfunction

  assign cmd = {bus.cmd_kind, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd,
                bus.cmd_imm, bus.cmd_target, bus.cmd_last};

  // Ready depends on state only, so there is no valid->ready path.
  assign rdy     = (state == S_LOAD);
  assign hs      = bus.cmd_valid & rdy;
  assign at_top  = (ptr == {AW{1'b1}});
  assign load_go = start & ((state == S_IDLE) | (state == S_ERR));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD: begin
        if (hs) begin
          if (cmd.last)    state_n = S_DRAIN;
          else if (at_top) state_n = S_ERR;
        end
      end
      S_DRAIN: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      S_ERR:   if (start) state_n = S_LOAD;
      default: state_n = S_IDLE;
    endcase
  end

  // Write pointer, word count, registered write port and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
      loaded  <= 1'b0;
    end else begin
      we_q <= hs;
      if (load_go) begin
        ptr     <= BASE;
        count_q <= '0;
        ovf_q   <= 1'b0;
        loaded  <= 1'b0;
      end else if (hs) begin
        addr_q  <= ptr;
        wdata_q <= encode(cmd);
        // On the final command at the top address the pointer wraps harmlessly.
        ptr     <= ptr + AW'(1);
        count_q <= count_q + (AW+1)'(1);
        if (!cmd.last && at_top) ovf_q <= 1'b1;
      end
      if (state == S_DONE) loaded <= 1'b1;
    end
  end

  assign bus.cmd_ready  = rdy;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign done           = (state == S_DONE);
  assign cpu_hold       = !((state == S_IDLE) && loaded);
  assign err_ovf        = ovf_q;
  assign count          = count_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a table of commands with
// hand-encoded words drives loads on a wide (AW=10) and a tiny (AW=2) loader.
module tb_imem_program_loader;
  localparam int AWA = 10;
  localparam int AWB = 2;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        dut;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sel = 1'b0, c_start = 1'b0, c_valid = 1'b0, c_last = 1'b0;
  logic [2:0]  c_kind = '0;
  logic [4:0]  c_rs = '0, c_rt = '0, c_rd = '0;
  logic [15:0] c_imm = '0;
  logic [25:0] c_tgt = '0;

  logic hold_a, done_a, ovf_a, hold_b, done_b, ovf_b;
  logic [AWA:0] count_a;
  logic [AWB:0] count_b;

  vec_t        vec [11];
  wr_t         wq[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0, n_bad = 0, cyc = 0;

  imem_program_loader_if #(.AW(AWA)) ifa ();
  imem_program_loader_if #(.AW(AWB)) ifb ();

  assign ifa.cmd_valid = c_valid & ~sel;
  assign ifb.cmd_valid = c_valid & sel;
  assign ifa.cmd_kind = c_kind;  assign ifb.cmd_kind = c_kind;
  assign ifa.cmd_rs = c_rs;      assign ifb.cmd_rs = c_rs;
  assign ifa.cmd_rt = c_rt;      assign ifb.cmd_rt = c_rt;
  assign ifa.cmd_rd = c_rd;      assign ifb.cmd_rd = c_rd;
  assign ifa.cmd_imm = c_imm;    assign ifb.cmd_imm = c_imm;
  assign ifa.cmd_target = c_tgt; assign ifb.cmd_target = c_tgt;
  assign ifa.cmd_last = c_last;  assign ifb.cmd_last = c_last;

  imem_program_loader #(.AW(AWA), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(c_start & ~sel), .bus(ifa),
    .cpu_hold(hold_a), .done(done_a), .err_ovf(ovf_a), .count(count_a)
  );

  imem_program_loader #(.AW(AWB), .BASE_ADDR(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(c_start & sel), .bus(ifb),
    .cpu_hold(hold_b), .done(done_b), .err_ovf(ovf_b), .count(count_b)
  );

  logic        w_ready, w_we, w_done, w_hold, w_ovf;
  logic [31:0] w_addr, w_wdata, w_count;
  assign w_ready = sel ? ifb.cmd_ready : ifa.cmd_ready;
  assign w_we    = sel ? ifb.imem_we : ifa.imem_we;
  assign w_done  = sel ? done_b : done_a;
  assign w_hold  = sel ? hold_b : hold_a;
  assign w_ovf   = sel ? ovf_b : ovf_a;
  assign w_addr  = sel ? 32'(ifb.imem_addr) : 32'(ifa.imem_addr);
  assign w_wdata = sel ? ifb.imem_wdata : ifa.imem_wdata;
  assign w_count = sel ? 32'(count_b) : 32'(count_a);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write of either loader.
  always @(negedge clk) begin
    if (ifa.imem_we === 1'b1) wq.push_back('{1'b0, 32'(ifa.imem_addr), ifa.imem_wdata, cyc});
    if (ifb.imem_we === 1'b1) wq.push_back('{1'b1, 32'(ifb.imem_addr), ifb.imem_wdata, cyc});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ready"}, w_ready, 0);
    chk({tag, " we"},    w_we,    0);
    chk({tag, " addr"},  w_addr,  0);
    chk({tag, " wdata"}, w_wdata, 0);
    chk({tag, " hold"},  w_hold,  1);
    chk({tag, " done"},  w_done,  0);
    chk({tag, " ovf"},   w_ovf,   0);
    chk({tag, " count"}, w_count, 0);
  endtask

  task automatic drive(input int idx);
    c_kind = vec[idx].kind; c_rs = vec[idx].rs; c_rt = vec[idx].rt;
    c_rd = vec[idx].rd; c_imm = vec[idx].imm; c_tgt = vec[idx].tgt;
  endtask

  // Entered and left at a negedge; holds the command until it is accepted.
  task automatic send(input int idx, input bit last, input bit rnd);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    drive(idx);
    c_last = last;
    while (!acc && guard < 64) begin
      c_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = c_valid && w_ready;
      @(negedge clk);
      guard++;
    end
    c_valid = 1'b0;
    c_last  = 1'b0;
    if (acc) exp_q.push_back(vec[idx].exp);
    else begin
      n_vec++; n_bad++;
      $display("FAIL send timeout: got no handshake for cmd %0d expected one within 64 cycles", idx);
    end
  endtask

  task automatic begin_load(input string tag);
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    chk({tag, " load ready"}, w_ready, 1);
    chk({tag, " load count"}, w_count, 0);
  endtask

  // Entered in the DRAIN cycle; st keeps start asserted through DRAIN and DONE.
  task automatic finish_load(input string tag, input int n, input bit st);
    chk({tag, " drain we"},   w_we,    1);
    chk({tag, " drain cnt"},  w_count, 32'(n));
    chk({tag, " drain done"}, w_done,  0);
    chk({tag, " drain hold"}, w_hold,  1);
    c_start = st;
    @(negedge clk);
    chk({tag, " done pulse"}, w_done,  1);
    chk({tag, " done hold"},  w_hold,  1);
    chk({tag, " done we"},    w_we,    0);
    chk({tag, " done cnt"},   w_count, 32'(n));
    @(negedge clk);
    c_start = 1'b0;
    chk({tag, " idle done"},  w_done,  0);
    chk({tag, " idle hold"},  w_hold,  0);
    chk({tag, " idle ready"}, w_ready, 0);
    chk({tag, " idle cnt"},   w_count, 32'(n));
  endtask

  task automatic check_writes(input string tag, input int first, input bit b2b);
    chk({tag, " nwr"}, 32'(wq.size()), 32'(exp_q.size()));
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
      chk({tag, " dut"},  32'(wq[i].dut), 32'(sel));
      chk({tag, " addr"}, wq[i].addr, 32'(first + i));
      chk({tag, " data"}, wq[i].data, exp_q[i]);
      if (b2b && i > 0) chk({tag, " b2b"}, 32'(wq[i].cyc - wq[i-1].cyc), 1);
    end
    wq.delete();
    exp_q.delete();
  endtask

  initial begin
    //          kind  rs     rt     rd     imm        target         expected word
    vec[0]  = '{3'd0, 5'd1,  5'd2,  5'd3,  16'hBEEF, 26'h155_5555, 32'h0022_1820}; // add
    vec[1]  = '{3'd2, 5'd0,  5'd5,  5'd17, 16'h00FF, 26'h2AA_AAAA, 32'h3405_00FF}; // ori
    vec[2]  = '{3'd3, 5'd1,  5'd4,  5'd9,  16'h0008, 26'h3FF_FFFF, 32'h8C24_0008}; // lw
    vec[3]  = '{3'd4, 5'd1,  5'd4,  5'd30, 16'h0004, 26'h123_4567, 32'hAC24_0004}; // sw
    vec[4]  = '{3'd6, 5'd9,  5'd9,  5'd9,  16'hFFFF, 26'h000_0010, 32'h0C00_0010}; // jal
    vec[5]  = '{3'd1, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 32'h03FF_F822}; // sub
    vec[6]  = '{3'd5, 5'd2,  5'd3,  5'd7,  16'hFFFE, 26'h000_0000, 32'h1043_FFFE}; // beq
    vec[7]  = '{3'd7, 5'd5,  5'd6,  5'd7,  16'h1234, 26'h3FF_FFFF, 32'h0000_0000}; // nop
    vec[8]  = '{3'd6, 5'd9,  5'd0,  5'd0,  16'h0000, 26'h3FF_FFFF, 32'h0FFF_FFFF}; // jal max
    vec[9]  = '{3'd0, 5'd0,  5'd0,  5'd0,  16'hABCD, 26'h000_0001, 32'h0000_0020}; // add r0
    vec[10] = '{3'd2, 5'd31, 5'd0,  5'd1,  16'h8000, 26'h000_0000, 32'h37E0_8000}; // ori

    // Reset values on both loaders.
    repeat (2) @(negedge clk);
    sel = 1'b0; #1; chk_reset("rst a");
    sel = 1'b1; #1; chk_reset("rst b");
    sel = 1'b0; #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle unloaded hold", w_hold, 1);

    // Single add; start and valid together in IDLE: only start acts.
    c_start = 1'b1; drive(0); c_last = 1'b1; c_valid = 1'b1;
    chk("t1 idle ready", w_ready, 0);
    @(negedge clk);
    c_start = 1'b0;
    chk("t1 no early we", w_we, 0);
    chk("t1 load cnt", w_count, 0);
    chk("t1 load ready", w_ready, 1);
    exp_q.push_back(vec[0].exp);
    @(negedge clk);
    c_valid = 1'b0; c_last = 1'b0;
    finish_load("t1", 1, 1'b0);
    check_writes("t1", 0, 1'b1);

    // Back-to-back ori/lw/sw/jal.
    begin_load("t2");
    send(1, 1'b0, 1'b0); send(2, 1'b0, 1'b0); send(3, 1'b0, 1'b0); send(4, 1'b1, 1'b0);
    finish_load("t2", 4, 1'b0);
    check_writes("t2", 0, 1'b1);

    // Whole table back-to-back, every kind with junk in unused fields.
    begin_load("t3");
    for (int i = 0; i < 11; i++) send(i, i == 10, 1'b0);
    finish_load("t3", 11, 1'b0);
    check_writes("t3", 0, 1'b1);

    // Random valid gaps: contiguous addresses, no duplicates.
    begin_load("t4");
    for (int i = 0; i < 8; i++) send((i * 3) % 11, i == 7, 1'b1);
    finish_load("t4", 8, 1'b0);
    check_writes("t4", 0, 1'b0);

    // Reset after two accepted commands abandons the load.
    begin_load("t5");
    send(0, 1'b0, 1'b0); send(1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t5 rst");
    check_writes("t5 pre", 0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5 idle hold", w_hold, 1);
    begin_load("t5r");
    send(6, 1'b1, 1'b0);
    finish_load("t5r", 1, 1'b0);
    check_writes("t5r", 0, 1'b1);

    // start ignored in LOAD, DRAIN and DONE.
    begin_load("t6");
    send(2, 1'b0, 1'b0); send(3, 1'b0, 1'b0);
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    chk("t6 cnt kept", w_count, 2);
    chk("t6 still load", w_ready, 1);
    send(4, 1'b1, 1'b0);
    finish_load("t6", 3, 1'b1);
    check_writes("t6", 0, 1'b0);

    // AW=2: overflow after four words, then recovery and wrap on the last word.
    sel = 1'b1; #1;
    begin_load("t7");
    chk("t7 ovf clear", w_ovf, 0);
    for (int i = 0; i < 4; i++) send(i, 1'b0, 1'b0);
    chk("t7 err ovf",   w_ovf,   1);
    chk("t7 err ready", w_ready, 0);
    chk("t7 err hold",  w_hold,  1);
    chk("t7 err cnt",   w_count, 4);
    drive(4); c_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t7 fifth ready", w_ready, 0);
      chk("t7 fifth we",    w_we,    0);
      chk("t7 err sticky",  w_ovf,   1);
    end
    c_valid = 1'b0;
    chk("t7 cnt held", w_count, 4);
    check_writes("t7", 0, 1'b1);
    begin_load("t7r");
    chk("t7r ovf cleared", w_ovf, 0);
    for (int i = 0; i < 4; i++) send(i + 5, i == 3, 1'b0);
    finish_load("t7r", 4, 1'b0);
    chk("t7r no ovf", w_ovf, 0);
    check_writes("t7r", 0, 1'b1);
    sel = 1'b0; #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
